// File: rtl/aclk_pkg.sv
// Shared types and helpers for the multi-alarm BCD clock.
// The SNOOZE state exists only when ACLK_SNOOZE_EN is defined.
package aclk_pkg;

  localparam int SEC_PER_MIN = 60;

  typedef struct packed {
    logic [1:0] h1;
    logic [3:0] h0;
    logic [3:0] m1;
    logic [3:0] m0;
    logic [3:0] s1;
    logic [3:0] s0;
  } bcd_time_t;

  typedef enum logic [1:0] {
    AL_OFF,
    AL_ARMED,
    AL_RINGING
`ifdef ACLK_SNOOZE_EN
    , AL_SNOOZE
`endif
  } alarm_state_e;

  function automatic logic bcd_hm_valid(input logic [1:0] h1, input logic [3:0] h0,
                                        input logic [3:0] m1, input logic [3:0] m0);
    return (h0 <= 4'd9) && (m1 <= 4'd5) && (m0 <= 4'd9) &&
           ((h1 < 2'd2) || ((h1 == 2'd2) && (h0 <= 4'd3)));
  endfunction

  // One-second BCD increment with 23:59:59 -> 00:00:00 rollover.
  function automatic bcd_time_t bcd_inc(input bcd_time_t t);
    bcd_time_t r;
    r = t;
    if (t.s0 != 4'd9) r.s0 = t.s0 + 4'd1;
    else begin
      r.s0 = '0;
      if (t.s1 != 4'd5) r.s1 = t.s1 + 4'd1;
      else begin
        r.s1 = '0;
        if (t.m0 != 4'd9) r.m0 = t.m0 + 4'd1;
        else begin
          r.m0 = '0;
          if (t.m1 != 4'd5) r.m1 = t.m1 + 4'd1;
          else begin
            r.m1 = '0;
            if ((t.h1 == 2'd2) && (t.h0 == 4'd3)) begin
              r.h1 = '0;
              r.h0 = '0;
            end else if (t.h0 == 4'd9) begin
              r.h0 = '0;
              r.h1 = t.h1 + 2'd1;
            end else r.h0 = t.h0 + 4'd1;
          end
        end
      end
    end
    return r;
  endfunction

endpackage

// File: rtl/aclk_multi_alarm_if.sv
// Configuration/display bus of the multi-alarm clock.
// The snooze line exists only when ACLK_SNOOZE_EN is defined.
interface aclk_multi_alarm_if #(parameter int NUM_ALARMS = 4);
  localparam int SEL_W = (NUM_ALARMS > 1) ? $clog2(NUM_ALARMS) : 1;

  logic [1:0]            H_in1;
  logic [3:0]            H_in0, M_in1, M_in0;
  logic                  LD_time, LD_alarm;
  logic [SEL_W-1:0]      alarm_sel;
  logic                  alarm_en_in;
  logic                  stop_alarm;
`ifdef ACLK_SNOOZE_EN
  logic                  snooze;
`endif
  logic [1:0]            H_out1;
  logic [3:0]            H_out0, M_out1, M_out0, S_out1, S_out0;
  logic                  sec_tick;
  logic [NUM_ALARMS-1:0] alarm_active;
  logic                  alarm;
  logic                  ld_err;

  modport master (
`ifdef ACLK_SNOOZE_EN
    output snooze,
`endif
    output H_in1, H_in0, M_in1, M_in0, LD_time, LD_alarm, alarm_sel, alarm_en_in, stop_alarm,
    input  H_out1, H_out0, M_out1, M_out0, S_out1, S_out0, sec_tick, alarm_active, alarm, ld_err
  );

  modport slave (
`ifdef ACLK_SNOOZE_EN
    input  snooze,
`endif
    input  H_in1, H_in0, M_in1, M_in0, LD_time, LD_alarm, alarm_sel, alarm_en_in, stop_alarm,
    output H_out1, H_out0, M_out1, M_out0, S_out1, S_out0, sec_tick, alarm_active, alarm, ld_err
  );
endinterface

// File: rtl/aclk_alarm_ch.sv
// One alarm channel: stored HH:MM, state machine, ring timeout and
// (with ACLK_SNOOZE_EN) snooze countdown.
module aclk_alarm_ch
  import aclk_pkg::*;
#(
  parameter int RING_SECONDS = 60
`ifdef ACLK_SNOOZE_EN
  , parameter int SNOOZE_MIN = 5
`endif
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       ld,
  input  logic       ld_en,
  input  logic [13:0] ld_hm,
  input  logic       tick,
  input  bcd_time_t  now,
  input  logic       stop,
`ifdef ACLK_SNOOZE_EN
  input  logic       snooze,
`endif
  output logic       active
);
  localparam int RW = (RING_SECONDS > 1) ? $clog2(RING_SECONDS) : 1;

  alarm_state_e st_q, st_d;
  logic [13:0]  hm_q, hm_d;
  logic [RW-1:0] ring_q, ring_d;
  logic         match;

`ifdef ACLK_SNOOZE_EN
  localparam int SNZ_TICKS = SNOOZE_MIN * SEC_PER_MIN;
  localparam int SW = (SNZ_TICKS > 1) ? $clog2(SNZ_TICKS) : 1;
  logic [SW-1:0] snz_q, snz_d;
`endif

  // Trigger only on a counted second, so a time load onto HH:MM:00 is silent.
  assign match  = tick && (now == {hm_q, 8'h00});
  assign active = (st_q == AL_RINGING);

  always_comb begin
    st_d   = st_q;
    hm_d   = hm_q;
    ring_d = ring_q;
`ifdef ACLK_SNOOZE_EN
    snz_d  = snz_q;
`endif
    if (ld) begin
      hm_d   = ld_hm;
      st_d   = ld_en ? AL_ARMED : AL_OFF;
      ring_d = '0;
    end else begin
      case (st_q)
        AL_ARMED: if (match) begin
          st_d   = AL_RINGING;
          ring_d = '0;
        end
        AL_RINGING: begin
          if (stop) st_d = AL_ARMED;
`ifdef ACLK_SNOOZE_EN
          else if (snooze) begin
            st_d  = AL_SNOOZE;
            snz_d = '0;
          end
`endif
          else if (tick) begin
            if (ring_q == RW'(RING_SECONDS - 1)) st_d = AL_ARMED;
            else ring_d = ring_q + RW'(1);
          end
        end
`ifdef ACLK_SNOOZE_EN
        AL_SNOOZE: begin
          if (stop) st_d = AL_ARMED;
          else if (tick) begin
            if (snz_q == SW'(SNZ_TICKS - 1)) begin
              st_d   = AL_RINGING;
              ring_d = '0;
            end else snz_d = snz_q + SW'(1);
          end
        end
`endif
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      st_q   <= AL_OFF;
      hm_q   <= '0;
      ring_q <= '0;
`ifdef ACLK_SNOOZE_EN
      snz_q  <= '0;
`endif
    end else begin
      st_q   <= st_d;
      hm_q   <= hm_d;
      ring_q <= ring_d;
`ifdef ACLK_SNOOZE_EN
      snz_q  <= snz_d;
`endif
    end
  end

endmodule

// File: rtl/aclk_multi_alarm.sv
// 24-hour BCD clock with prescaler, validated loads and NUM_ALARMS channels.
// Define ACLK_SNOOZE_EN to add the snooze input and SNOOZE state.
module aclk_multi_alarm
  import aclk_pkg::*;
#(
  parameter int TICKS_PER_SEC = 10,
  parameter int NUM_ALARMS    = 4,
  parameter int RING_SECONDS  = 60,
  parameter int SNOOZE_MIN    = 5
) (
  input logic              clk,
  input logic              reset,
  aclk_multi_alarm_if.slave bus
);
  localparam int PW    = $clog2(TICKS_PER_SEC);
  localparam int SEL_W = (NUM_ALARMS > 1) ? $clog2(NUM_ALARMS) : 1;

  if (TICKS_PER_SEC < 2 || NUM_ALARMS < 1 || RING_SECONDS < 1 || SNOOZE_MIN < 1) begin : g_bad_cfg
    $error("aclk_multi_alarm: parameter out of range");
  end

  logic [PW-1:0]         presc_q, presc_d;
  bcd_time_t             time_q, time_d;
  logic                  tick_q, tick_d;
  logic                  ld_err_q, ld_err_d;
  logic                  time_ok, alarm_ok;
  logic [13:0]           ld_hm;
  logic [NUM_ALARMS-1:0] ch_ld, active;

  assign ld_hm = {bus.H_in1, bus.H_in0, bus.M_in1, bus.M_in0};

  always_comb begin
    time_ok  = bcd_hm_valid(bus.H_in1, bus.H_in0, bus.M_in1, bus.M_in0);
    alarm_ok = time_ok && (int'(bus.alarm_sel) < NUM_ALARMS);
    ld_err_d = (bus.LD_time && !time_ok) || (bus.LD_alarm && !alarm_ok);
    presc_d  = presc_q + PW'(1);
    tick_d   = 1'b0;
    time_d   = time_q;
    // A valid load restarts the second, so it suppresses a coincident tick.
    if (bus.LD_time && time_ok) begin
      presc_d = '0;
      time_d  = {ld_hm, 8'h00};
    end else if (presc_q == PW'(TICKS_PER_SEC - 1)) begin
      presc_d = '0;
      tick_d  = 1'b1;
      time_d  = bcd_inc(time_q);
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      presc_q  <= '0;
      time_q   <= '0;
      tick_q   <= 1'b0;
      ld_err_q <= 1'b0;
    end else begin
      presc_q  <= presc_d;
      time_q   <= time_d;
      tick_q   <= tick_d;
      ld_err_q <= ld_err_d;
    end
  end

  for (genvar n = 0; n < NUM_ALARMS; n++) begin : g_ch
    assign ch_ld[n] = bus.LD_alarm && alarm_ok && (bus.alarm_sel == SEL_W'(n));

    aclk_alarm_ch #(
      .RING_SECONDS(RING_SECONDS)
`ifdef ACLK_SNOOZE_EN
      , .SNOOZE_MIN(SNOOZE_MIN)
`endif
    ) u_ch (
      .clk    (clk),
      .reset  (reset),
      .ld     (ch_ld[n]),
      .ld_en  (bus.alarm_en_in),
      .ld_hm  (ld_hm),
      .tick   (tick_q),
      .now    (time_q),
      .stop   (bus.stop_alarm),
`ifdef ACLK_SNOOZE_EN
      .snooze (bus.snooze),
`endif
      .active (active[n])
    );
  end

  assign bus.H_out1       = time_q.h1;
  assign bus.H_out0       = time_q.h0;
  assign bus.M_out1       = time_q.m1;
  assign bus.M_out0       = time_q.m0;
  assign bus.S_out1       = time_q.s1;
  assign bus.S_out0       = time_q.s0;
  assign bus.sec_tick     = tick_q;
  assign bus.ld_err       = ld_err_q;
  assign bus.alarm_active = active;
  assign bus.alarm        = |active;

endmodule

// File: tb/tb_aclk_multi_alarm.sv
// Directed bench for aclk_multi_alarm: seconds-of-day reference model checked
// every cycle, plus hand-computed literal expectations at key points.
module tb_aclk_multi_alarm;
  localparam int TPS  = 10;
  localparam int NA   = 4;
  localparam int RING = 60;
  localparam int SNZ  = 5;

  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  aclk_multi_alarm_if #(.NUM_ALARMS(NA)) bus ();

  aclk_multi_alarm #(
    .TICKS_PER_SEC(TPS), .NUM_ALARMS(NA), .RING_SECONDS(RING), .SNOOZE_MIN(SNZ)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  int checks = 0;
  int errors = 0;

  // Reference model: time as seconds since midnight, channels as small ints.
  int m_secs, m_presc;
  bit m_tick, m_err;
  int m_hm[NA];
  int m_st[NA];   // 0 off, 1 armed, 2 ringing, 3 snoozed
  int m_left[NA];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [21:0] dut_time();
    return {bus.H_out1, bus.H_out0, bus.M_out1, bus.M_out0, bus.S_out1, bus.S_out0};
  endfunction

  function automatic logic [21:0] enc(input int secs);
    int h, m, s;
    h = secs / 3600;
    m = (secs / 60) % 60;
    s = secs % 60;
    return {2'(h / 10), 4'(h % 10), 4'(m / 10), 4'(m % 10), 4'(s / 10), 4'(s % 10)};
  endfunction

  function automatic bit hm_ok(input int h1, input int h0, input int m1, input int m0);
    return (h0 <= 9) && (m1 <= 5) && (m0 <= 9) && ((h1 * 10 + h0) <= 23);
  endfunction

  task automatic model_step();
    bit s_in, lt_ok, la_ok;
    int hh, mm;
    s_in = 1'b0;
`ifdef ACLK_SNOOZE_EN
    s_in = bus.snooze;
`endif
    if (reset) begin
      m_secs = 0; m_presc = 0; m_tick = 0; m_err = 0;
      for (int n = 0; n < NA; n++) begin
        m_hm[n] = 0; m_st[n] = 0; m_left[n] = 0;
      end
      return;
    end
    lt_ok = hm_ok(int'(bus.H_in1), int'(bus.H_in0), int'(bus.M_in1), int'(bus.M_in0));
    la_ok = lt_ok && (int'(bus.alarm_sel) < NA);
    hh = int'(bus.H_in1) * 10 + int'(bus.H_in0);
    mm = int'(bus.M_in1) * 10 + int'(bus.M_in0);
    for (int n = 0; n < NA; n++) begin
      if (bus.LD_alarm && la_ok && int'(bus.alarm_sel) == n) begin
        m_hm[n] = hh * 60 + mm;
        m_st[n] = bus.alarm_en_in ? 1 : 0;
      end else begin
        case (m_st[n])
          1: if (m_tick && (m_secs % 60 == 0) && (m_secs / 60 == m_hm[n])) begin
               m_st[n] = 2; m_left[n] = RING;
             end
          2: if (bus.stop_alarm) m_st[n] = 1;
             else if (s_in) begin m_st[n] = 3; m_left[n] = SNZ * 60; end
             else if (m_tick) begin
               m_left[n]--;
               if (m_left[n] == 0) m_st[n] = 1;
             end
          3: if (bus.stop_alarm) m_st[n] = 1;
             else if (m_tick) begin
               m_left[n]--;
               if (m_left[n] == 0) begin m_st[n] = 2; m_left[n] = RING; end
             end
          default: ;
        endcase
      end
    end
    m_err = (bus.LD_time && !lt_ok) || (bus.LD_alarm && !la_ok);
    if (bus.LD_time && lt_ok) begin
      m_secs = (hh * 60 + mm) * 60; m_presc = 0; m_tick = 0;
    end else if (m_presc == TPS - 1) begin
      m_presc = 0; m_secs = (m_secs + 1) % 86400; m_tick = 1;
    end else begin
      m_presc++; m_tick = 0;
    end
  endtask

  // Advance one clock: update the model from the sampled inputs, then compare.
  task automatic cycle();
    logic [NA-1:0] exp_act;
    model_step();
    @(posedge clk);
    #1;
    exp_act = '0;
    for (int n = 0; n < NA; n++) exp_act[n] = (m_st[n] == 2);
    chk("time", 32'(dut_time()), 32'(enc(m_secs)));
    chk("sec_tick", 32'(bus.sec_tick), 32'(m_tick));
    chk("alarm_active", 32'(bus.alarm_active), 32'(exp_act));
    chk("alarm", 32'(bus.alarm), 32'(|exp_act));
    chk("ld_err", 32'(bus.ld_err), 32'(m_err));
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) cycle();
  endtask

  task automatic set_hm(input int h1, input int h0, input int m1, input int m0);
    bus.H_in1 = 2'(h1); bus.H_in0 = 4'(h0); bus.M_in1 = 4'(m1); bus.M_in0 = 4'(m0);
  endtask

  task automatic ld_time(input int h1, input int h0, input int m1, input int m0);
    set_hm(h1, h0, m1, m0);
    bus.LD_time = 1'b1;
    cycle();
    bus.LD_time = 1'b0;
  endtask

  task automatic ld_alarm(input int sel, input bit en,
                          input int h1, input int h0, input int m1, input int m0);
    set_hm(h1, h0, m1, m0);
    bus.alarm_sel = 2'(sel);
    bus.alarm_en_in = en;
    bus.LD_alarm = 1'b1;
    cycle();
    bus.LD_alarm = 1'b0;
  endtask

  initial begin
    bus.LD_time = 1'b0; bus.LD_alarm = 1'b0; bus.alarm_sel = '0;
    bus.alarm_en_in = 1'b0; bus.stop_alarm = 1'b0;
`ifdef ACLK_SNOOZE_EN
    bus.snooze = 1'b0;
`endif
    set_hm(0, 0, 0, 0);

    // Reset state
    cycle();
    chk("rst_time", 32'(dut_time()), 32'd0);
    chk("rst_alarm", 32'(bus.alarm), 32'd0);
    reset = 1'b0;

    // First tick after exactly TPS cycles
    run(9);
    chk("pre_tick", 32'(bus.sec_tick), 32'd0);
    cycle();
    chk("first_tick", 32'(bus.sec_tick), 32'd1);
    chk("time_000001", 32'(dut_time()), 32'd1);

    // Asynchronous reset mid-count clears time without a clock edge
    run(3);
    reset = 1'b1;
    #1;
    chk("async_rst_time", 32'(dut_time()), 32'd0);
    cycle();
    reset = 1'b0;

    // 23:59 rollover through every carry
    ld_time(2, 3, 5, 9);
    chk("ld_2359", 32'(dut_time()), 32'({2'd2, 4'd3, 4'd5, 4'd9, 8'd0}));
    run(590);
    chk("time_235959", 32'(dut_time()), 32'({2'd2, 4'd3, 4'd5, 4'd9, 4'd5, 4'd9}));
    run(10);
    chk("rollover", 32'(dut_time()), 32'd0);
    chk("rollover_tick", 32'(bus.sec_tick), 32'd1);

    // Rejected loads
    ld_time(2, 4, 0, 0);
    chk("err_h24", 32'(bus.ld_err), 32'd1);
    cycle();
    chk("err_once", 32'(bus.ld_err), 32'd0);
    ld_time(1, 2, 6, 0);
    chk("err_m60", 32'(bus.ld_err), 32'd1);
    ld_time(0, 10, 0, 0);
    chk("err_digit", 32'(bus.ld_err), 32'd1);
    ld_alarm(1, 1'b1, 2, 4, 0, 0);
    chk("err_alarm", 32'(bus.ld_err), 32'd1);
    set_hm(2, 5, 0, 0);
    bus.LD_time = 1'b1; bus.LD_alarm = 1'b1;
    cycle();
    bus.LD_time = 1'b0; bus.LD_alarm = 1'b0;
    chk("err_both", 32'(bus.ld_err), 32'd1);
    cycle();
    chk("err_both_once", 32'(bus.ld_err), 32'd0);

    // Channel 2 at 00:01, ring then timeout
    ld_alarm(2, 1'b1, 0, 0, 0, 1);
    ld_time(0, 0, 0, 0);
    run(600);
    chk("at_0001", 32'(dut_time()), 32'({2'd0, 4'd0, 4'd0, 4'd1, 8'd0}));
    chk("not_yet", 32'(bus.alarm_active), 32'd0);
    cycle();
    chk("ring_ch2", 32'(bus.alarm_active), 32'b0100);
    chk("ring_alarm", 32'(bus.alarm), 32'd1);
    run(599);
    chk("still_ring", 32'(bus.alarm_active), 32'b0100);
    cycle();
    chk("timeout", 32'(bus.alarm_active), 32'd0);

    // Load onto the alarm minute does not trigger
    ld_time(0, 0, 0, 1);
    run(2);
    chk("ld_no_trig", 32'(bus.alarm_active), 32'd0);

    // stop_alarm clears immediately
    ld_time(0, 0, 0, 0);
    run(601);
    chk("ring_again", 32'(bus.alarm_active), 32'b0100);
    bus.stop_alarm = 1'b1;
    cycle();
    bus.stop_alarm = 1'b0;
    chk("stopped", 32'(bus.alarm_active), 32'd0);

    // Channels 0 and 3 together; stop on the match cycle loses
    ld_alarm(2, 1'b0, 0, 0, 0, 0);
    ld_alarm(0, 1'b1, 0, 0, 0, 1);
    ld_alarm(3, 1'b1, 0, 0, 0, 1);
    ld_time(0, 0, 0, 0);
    run(600);
    bus.stop_alarm = 1'b1;
    cycle();
    bus.stop_alarm = 1'b0;
    chk("multi_ring", 32'(bus.alarm_active), 32'b1001);

`ifdef ACLK_SNOOZE_EN
    bus.snooze = 1'b1;
    cycle();
    bus.snooze = 1'b0;
    chk("snoozed", 32'(bus.alarm_active), 32'd0);
    run(2998);
    chk("at_0006", 32'(dut_time()), 32'({2'd0, 4'd0, 4'd0, 4'd6, 8'd0}));
    chk("snz_quiet", 32'(bus.alarm_active), 32'd0);
    cycle();
    chk("re_ring", 32'(bus.alarm_active), 32'b1001);
`endif
    bus.stop_alarm = 1'b1;
    cycle();
    bus.stop_alarm = 1'b0;
    chk("final_stop", 32'(bus.alarm_active), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
